// File: rtl/uart_time_reporter.sv
// Streams the current time to the UART TX as a 15-byte ASCII record "M hh:mm:ss.cc\r\n".
// Define PERIODIC_REPORT_EN to make every tick_1s_i pulse a report trigger as well as req_i.
module uart_time_reporter #(
    parameter int unsigned TIMEOUT_CYC = 250000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_i,
    input  logic       tick_1s_i,
    input  logic       mode_i,
    input  logic [4:0] hour_i,
    input  logic [5:0] min_i,
    input  logic [5:0] sec_i,
    input  logic [6:0] csec_i,
    input  logic       tx_done_i,
    output logic       tx_start_o,
    output logic [7:0] tx_din_o,
    output logic       busy_o,
    output logic       err_o
);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StLatch, StSend, StWait} state_e;

    state_e          state_q;
    logic [3:0]      idx_q;
    logic [CntW-1:0] cnt_q;
    logic            pend_q;
    logic            err_q;
    logic            busy_q;
    logic            tx_start_q;
    logic [7:0]      tx_din_q;
    logic            snap_mode_q;
    logic [4:0]      snap_hour_q;
    logic [5:0]      snap_min_q;
    logic [5:0]      snap_sec_q;
    logic [6:0]      snap_csec_q;
    logic [7:0]      byte_sel;
    logic            trig;

`ifdef PERIODIC_REPORT_EN
    assign trig = req_i | tick_1s_i;
`else
    logic unused_tick;
    assign unused_tick = tick_1s_i;
    assign trig        = req_i;
`endif

    // Two-digit decimal field; anything above 99 saturates to "99".
    function automatic logic [7:0] ascii_digit(input logic [6:0] v, input logic tens);
        logic [6:0] c;
        c = (v > 7'd99) ? 7'd99 : v;
        return tens ? (8'h30 + {1'b0, c / 7'd10}) : (8'h30 + {1'b0, c % 7'd10});
    endfunction

    always_comb begin
        byte_sel = 8'h00;
        case (idx_q)
            4'd0:    byte_sel = snap_mode_q ? 8'h53 : 8'h57;
            4'd1:    byte_sel = 8'h20;
            4'd2:    byte_sel = ascii_digit({2'b00, snap_hour_q}, 1'b1);
            4'd3:    byte_sel = ascii_digit({2'b00, snap_hour_q}, 1'b0);
            4'd4:    byte_sel = 8'h3A;
            4'd5:    byte_sel = ascii_digit({1'b0, snap_min_q}, 1'b1);
            4'd6:    byte_sel = ascii_digit({1'b0, snap_min_q}, 1'b0);
            4'd7:    byte_sel = 8'h3A;
            4'd8:    byte_sel = ascii_digit({1'b0, snap_sec_q}, 1'b1);
            4'd9:    byte_sel = ascii_digit({1'b0, snap_sec_q}, 1'b0);
            4'd10:   byte_sel = 8'h2E;
            4'd11:   byte_sel = ascii_digit(snap_csec_q, 1'b1);
            4'd12:   byte_sel = ascii_digit(snap_csec_q, 1'b0);
            4'd13:   byte_sel = 8'h0D;
            4'd14:   byte_sel = 8'h0A;
            default: byte_sel = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            idx_q       <= 4'd0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_din_q    <= 8'h00;
            snap_mode_q <= 1'b0;
            snap_hour_q <= 5'd0;
            snap_min_q  <= 6'd0;
            snap_sec_q  <= 6'd0;
            snap_csec_q <= 7'd0;
        end else begin
            tx_start_q <= 1'b0;
            if (trig && state_q != StIdle) begin
                pend_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (trig) begin
                        state_q <= StLatch;
                        busy_q  <= 1'b1;
                        err_q   <= 1'b0;
                    end
                end
                // Byte 0 only needs the mode bit, so it launches straight from the live input
                // while the rest of the record is snapshotted; this keeps req->tx_start at 2.
                StLatch: begin
                    snap_mode_q <= mode_i;
                    snap_hour_q <= hour_i;
                    snap_min_q  <= min_i;
                    snap_sec_q  <= sec_i;
                    snap_csec_q <= csec_i;
                    idx_q       <= 4'd0;
                    tx_din_q    <= mode_i ? 8'h53 : 8'h57;
                    tx_start_q  <= 1'b1;
                    cnt_q       <= '0;
                    state_q     <= StWait;
                end
                StSend: begin
                    tx_din_q   <= byte_sel;
                    tx_start_q <= 1'b1;
                    cnt_q      <= '0;
                    state_q    <= StWait;
                end
                StWait: begin
                    if (tx_done_i) begin
                        if (idx_q == 4'd14) begin
                            if (pend_q || trig) begin
                                pend_q  <= 1'b0;
                                state_q <= StLatch;
                            end else begin
                                busy_q  <= 1'b0;
                                state_q <= StIdle;
                            end
                        end else begin
                            idx_q   <= idx_q + 4'd1;
                            state_q <= StSend;
                        end
                    end else if (cnt_q == CntLast) begin
                        pend_q  <= 1'b0;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx_start_o = tx_start_q;
    assign tx_din_o   = tx_din_q;
    assign busy_o     = busy_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_uart_time_reporter.sv
// Scoreboard bench for uart_time_reporter: expected record bytes are queued at request time
// and matched against bytes captured from tx_start; a responder returns tx_done 10 cycles later.
`timescale 1ns/1ps
module tb_uart_time_reporter;
    localparam int unsigned TO = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic       tick_1s = 1'b0;
    logic       mode = 1'b0;
    logic [4:0] hour = 5'd0;
    logic [5:0] min = 6'd0;
    logic [5:0] sec = 6'd0;
    logic [6:0] csec = 7'd0;
    logic       tx_done = 1'b0;
    logic       tx_start;
    logic [7:0] tx_din;
    logic       busy;
    logic       err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         start_q[$];
    int         done_q[$];
    bit         resp_en = 1'b1;
    int         done_cnt = 0;
    logic [7:0] held = 8'h00;
    int         unstable = 0;

    logic [7:0] basic_bytes[15] = '{8'h57, 8'h20, 8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A,
                                    8'h35, 8'h36, 8'h2E, 8'h37, 8'h38, 8'h0D, 8'h0A};

    uart_time_reporter #(.TIMEOUT_CYC(TO)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_i      (req),
        .tick_1s_i  (tick_1s),
        .mode_i     (mode),
        .hour_i     (hour),
        .min_i      (min),
        .sec_i      (sec),
        .csec_i     (csec),
        .tx_done_i  (tx_done),
        .tx_start_o (tx_start),
        .tx_din_o   (tx_din),
        .busy_o     (busy),
        .err_o      (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // UART stand-in: capture each launched byte, answer with tx_done 10 cycles later.
    always @(negedge clk) begin
        tx_done = 1'b0;
        if (!rst_n) begin
            done_cnt = 0;
        end else begin
            if (done_cnt > 0) begin
                if (tx_din !== held) unstable++;
                done_cnt--;
                if (done_cnt == 0) begin
                    tx_done = 1'b1;
                    done_q.push_back(cyc);
                end
            end
            if (tx_start === 1'b1) begin
                got_q.push_back(tx_din);
                start_q.push_back(cyc);
                held = tx_din;
                if (resp_en) done_cnt = 10;
            end
        end
    end

    function automatic logic [7:0] dig(input int v, input bit tens);
        int c;
        c = (v >= 100) ? 99 : v;
        return tens ? 8'(48 + c / 10) : 8'(48 + c % 10);
    endfunction

    task automatic push_record(input bit m, input int h, input int mi, input int s,
                               input int cs);
        exp_q.push_back(m ? 8'h53 : 8'h57);
        exp_q.push_back(8'h20);
        exp_q.push_back(dig(h, 1'b1));
        exp_q.push_back(dig(h, 1'b0));
        exp_q.push_back(8'h3A);
        exp_q.push_back(dig(mi, 1'b1));
        exp_q.push_back(dig(mi, 1'b0));
        exp_q.push_back(8'h3A);
        exp_q.push_back(dig(s, 1'b1));
        exp_q.push_back(dig(s, 1'b0));
        exp_q.push_back(8'h2E);
        exp_q.push_back(dig(cs, 1'b1));
        exp_q.push_back(dig(cs, 1'b0));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic clear_logs();
        exp_q.delete();
        got_q.delete();
        start_q.delete();
        done_q.delete();
    endtask

    task automatic pulse_req();
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_got(input int n, input int bound, output bit ok);
        int i;
        i = 0;
        while (got_q.size() < n && i < bound) begin
            @(negedge clk);
            i++;
        end
        ok = (got_q.size() >= n);
    endtask

    task automatic wait_idle(input int bound);
        int i;
        i = 0;
        while (busy === 1'b1 && i < bound) begin
            @(negedge clk);
            i++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (tx_start !== 1'b0 || tx_din !== 8'h00 || busy !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: start=%b din=%02h busy=%b err=%b required 0 00 0 0",
                     tx_start, tx_din, busy, err);
        end
    endtask

    task automatic test_basic();
        int n, m, bad;
        bit ok;
        logic [7:0] g, w;
        clear_logs();
        mode = 1'b0; hour = 5'd12; min = 6'd34; sec = 6'd56; csec = 7'd78;
        for (int i = 0; i < 15; i++) exp_q.push_back(basic_bytes[i]);
        n = cyc;
        pulse_req();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy_n1: busy=%b required 1", busy);
        end
        for (int i = 0; i < 15; i++) begin
            wait_got(1, 300, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL basic_byte%0d: no tx_start, required %02h", i, exp_q[0]);
                break;
            end
            g = got_q.pop_front();
            w = exp_q.pop_front();
            if (g !== w) begin
                failures++;
                $display("FAIL basic_byte%0d: got %02h required %02h", i, g, w);
            end
        end
        checks++;
        if (start_q.size() < 1 || start_q[0] != n + 2) begin
            failures++;
            $display("FAIL basic_first_start: cycle %0d required %0d",
                     (start_q.size() > 0) ? start_q[0] - n : -1, 2);
        end
        for (int i = 0; i < 40 && done_q.size() < 15; i++) @(negedge clk);
        bad = 0;
        for (int i = 1; i < 15 && i < start_q.size() && i <= done_q.size(); i++)
            if (start_q[i] - done_q[i-1] != 2) bad++;
        checks++;
        if (bad != 0 || start_q.size() != 15 || done_q.size() != 15) begin
            failures++;
            $display("FAIL basic_done_to_start: %0d bad gaps, %0d starts, required 0 and 15",
                     bad, start_q.size());
        end
        m = (done_q.size() > 0) ? done_q[done_q.size()-1] : cyc;
        while (cyc < m + 1) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || got_q.size() != 0) begin
            failures++;
            $display("FAIL basic_end_idle: busy=%b extra=%0d required 0 0", busy, got_q.size());
        end
        checks++;
        if (unstable != 0) begin
            failures++;
            $display("FAIL basic_din_stable: %0d changes required 0", unstable);
        end
    endtask

    task automatic test_snapshot();
        bit ok;
        logic [7:0] g, w;
        clear_logs();
        push_record(1'b0, 12, 34, 56, 78);
        pulse_req();
        wait_got(1, 20, ok);
        sec = 6'd57;
        for (int i = 0; i < 15; i++) begin
            wait_got(1, 300, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL snap_byte%0d: no tx_start, required %02h", i, exp_q[0]);
                break;
            end
            g = got_q.pop_front();
            w = exp_q.pop_front();
            if (g !== w) begin
                failures++;
                $display("FAIL snap_byte%0d: got %02h required %02h", i, g, w);
            end
        end
        wait_idle(100);
        sec = 6'd56;
    endtask

    task automatic test_coalesce();
        bit ok;
        logic [7:0] g, w;
        clear_logs();
        push_record(1'b0, 12, 34, 56, 78);
        pulse_req();
        wait_got(3, 100, ok);
        push_record(1'b0, 12, 34, 56, 78);
        for (int k = 0; k < 3; k++) begin
            pulse_req();
            repeat (4) @(negedge clk);
        end
        for (int i = 0; i < 30; i++) begin
            wait_got(1, 300, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL coal_byte%0d: no tx_start, required %02h", i, exp_q[0]);
                break;
            end
            g = got_q.pop_front();
            w = exp_q.pop_front();
            if (g !== w) begin
                failures++;
                $display("FAIL coal_byte%0d: got %02h required %02h", i, g, w);
            end
        end
        checks++;
        if (start_q.size() < 16 || done_q.size() < 15 || start_q[15] - done_q[14] != 2) begin
            failures++;
            $display("FAIL coal_restart_gap: gap %0d required 2",
                     (start_q.size() >= 16 && done_q.size() >= 15) ?
                     start_q[15] - done_q[14] : -1);
        end
        wait_idle(100);
        repeat (50) @(negedge clk);
        checks++;
        if (got_q.size() != 0 || start_q.size() != 30 || busy !== 1'b0) begin
            failures++;
            $display("FAIL coal_record_count: %0d bytes busy=%b required 30 0",
                     start_q.size(), busy);
        end
    endtask

    task automatic test_timeout();
        int t, n;
        bit ok;
        logic [7:0] g, w;
        clear_logs();
        resp_en = 1'b0;
        pulse_req();
        wait_got(1, 20, ok);
        t = (start_q.size() > 0) ? start_q[0] : cyc;
        while (cyc < t + 49) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early: busy=%b err=%b required 1 0", busy, err);
        end
        while (cyc < t + 51) @(negedge clk);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || got_q.size() != 1) begin
            failures++;
            $display("FAIL timeout_abort: err=%b busy=%b bytes=%0d required 1 0 1",
                     err, busy, got_q.size());
        end
        clear_logs();
        resp_en = 1'b1;
        mode = 1'b0; hour = 5'd1; min = 6'd2; sec = 6'd3; csec = 7'd4;
        push_record(1'b0, 1, 2, 3, 4);
        n = cyc;
        pulse_req();
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_err_clear: err=%b busy=%b required 0 1", err, busy);
        end
        for (int i = 0; i < 15; i++) begin
            wait_got(1, 300, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL retry_byte%0d: no tx_start, required %02h", i, exp_q[0]);
                break;
            end
            g = got_q.pop_front();
            w = exp_q.pop_front();
            if (g !== w) begin
                failures++;
                $display("FAIL retry_byte%0d: got %02h required %02h", i, g, w);
            end
        end
        wait_idle(100);
    endtask

    task automatic test_clamp_mode();
        bit ok;
        logic [7:0] g, w;
        clear_logs();
        mode = 1'b1; hour = 5'd0; min = 6'd7; sec = 6'd9; csec = 7'd120;
        push_record(1'b1, 0, 7, 9, 120);
        pulse_req();
        for (int i = 0; i < 15; i++) begin
            wait_got(1, 300, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL clamp_byte%0d: no tx_start, required %02h", i, exp_q[0]);
                break;
            end
            g = got_q.pop_front();
            w = exp_q.pop_front();
            if (g !== w) begin
                failures++;
                $display("FAIL clamp_byte%0d: got %02h required %02h", i, g, w);
            end
        end
        wait_idle(100);
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [7:0] g, w;
        clear_logs();
        mode = 1'b0; hour = 5'd12; min = 6'd34; sec = 6'd56; csec = 7'd78;
        pulse_req();
        wait_got(6, 300, ok);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        repeat (100) @(negedge clk);
        checks++;
        if (got_q.size() != 0 || tx_start !== 1'b0 || tx_din !== 8'h00 || busy !== 1'b0 ||
            err !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_quiet: bytes=%0d start=%b din=%02h busy=%b err=%b required 0",
                     got_q.size(), tx_start, tx_din, busy, err);
        end
        tick_1s = 1'b1;
        @(negedge clk);
        tick_1s = 1'b0;
`ifdef PERIODIC_REPORT_EN
        push_record(1'b0, 12, 34, 56, 78);
        for (int i = 0; i < 15; i++) begin
            wait_got(1, 300, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL tick_byte%0d: no tx_start, required %02h", i, exp_q[0]);
                break;
            end
            g = got_q.pop_front();
            w = exp_q.pop_front();
            if (g !== w) begin
                failures++;
                $display("FAIL tick_byte%0d: got %02h required %02h", i, g, w);
            end
        end
        wait_idle(100);
`else
        g = 8'h00;
        w = 8'h00;
        repeat (100) @(negedge clk);
        checks++;
        if (got_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL tick_ignored: bytes=%0d busy=%b required 0 0 (g=%02h w=%02h)",
                     got_q.size(), busy, g, w);
        end
`endif
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_snapshot();
        test_coalesce();
        test_timeout();
        test_clamp_mode();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
